// File: rtl/bayer_demosaic_pkg.sv
// Shared types for the Bayer demosaic: CFA colour codes, output mode and the
// coordinate-to-colour mapping used by the window channel steering.
package bayer_pkg;

  typedef enum logic [1:0] {
    R  = 2'd0,
    GR = 2'd1,
    GB = 2'd2,
    B  = 2'd3
  } bayer_color_e;

  typedef enum logic {
    MODE_GREY = 1'b0,
    MODE_RGB  = 1'b1
  } mode_e;

  // Colour of the sample at (x,y): coordinate LSBs folded with the sensor phase.
  function automatic bayer_color_e bayer_color(input logic i_y0, input logic i_x0,
                                               input logic [1:0] i_phase);
    return bayer_color_e'({i_y0, i_x0} ^ i_phase);
  endfunction

endpackage

// File: rtl/bayer_demosaic_if.sv
// Pixel stream bundle between capture, the demosaic stage and the display path.
// master = pixel source / result sink, slave = demosaic stage.
interface bayer_demosaic_if #(
  parameter int DATA_W  = 12,
  parameter int COORD_W = 11
);
  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  logic [DATA_W-1:0]  iDATA;
  logic               iDVAL;
  logic               iMODE;
  logic [DATA_W-1:0]  oRED;
  logic [DATA_W-1:0]  oGREEN;
  logic [DATA_W-1:0]  oBLUE;
  logic [COORD_W-1:0] oX_Cont;
  logic [COORD_W-1:0] oY_Cont;
  logic               oDVAL;

  modport master (
    output iX_Cont, iY_Cont, iDATA, iDVAL, iMODE,
    input  oRED, oGREEN, oBLUE, oX_Cont, oY_Cont, oDVAL
  );

  modport slave (
    input  iX_Cont, iY_Cont, iDATA, iDVAL, iMODE,
    output oRED, oGREEN, oBLUE, oX_Cont, oY_Cont, oDVAL
  );
endinterface

// File: rtl/bayer_demosaic_line_buffer.sv
// One-line sample store: simple dual-port RAM with registered, read-first output.
// Holds the previous row so each pixel can see the sample directly above it.
module line_buffer #(
  parameter int DEPTH  = 1280,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              iCLK,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage and read register carry no reset so the array maps onto block RAM;
  // the top-border logic keeps undefined contents from ever reaching a result.
  always_ff @(posedge iCLK) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end
endmodule

// File: rtl/bayer_demosaic.sv
// Two-stage 2x2 Bayer demosaic producing greyscale, or R/G/B when the build
// defines BAYER_DEMOSAIC_RGB_EN (otherwise iMODE is ignored).
module bayer_demosaic
  import bayer_pkg::*;
#(
  parameter int         DATA_W      = 12,
  parameter int         COORD_W     = 11,
  parameter int         LINE_W      = 1280,
  parameter logic [1:0] BAYER_PHASE = 2'b00
) (
  input logic             iCLK,
  input logic             iRST,
  bayer_demosaic_if.slave bus
);
  localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int XCMP_W = COORD_W + 1;
  localparam int GREY_W = DATA_W + 2;
  localparam logic [XCMP_W-1:0]  X_LIMIT = XCMP_W'(LINE_W);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(LINE_W - 1);

  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Out-of-range columns are dropped before they can alias onto a RAM address.
  assign w_acc  = bus.iDVAL && ({1'b0, bus.iX_Cont} < X_LIMIT);
  assign w_addr = bus.iX_Cont[ADDR_W-1:0];

  line_buffer #(
    .DEPTH (LINE_W),
    .WIDTH (DATA_W),
    .ADDR_W(ADDR_W)
  ) u_line_buffer (
    .iCLK     (iCLK),
    .i_wr_en  (w_acc),
    .i_wr_addr(w_addr),
    .i_wr_data(bus.iDATA),
    .i_rd_en  (w_acc),
    .i_rd_addr(w_addr),
    .o_rd_data(w_rd_data)
  );

  logic               r_s1_val;
  logic [DATA_W-1:0]  r_s1_cur;
  logic [COORD_W-1:0] r_s1_x;
  logic [COORD_W-1:0] r_s1_y;
`ifdef BAYER_DEMOSAIC_RGB_EN
  mode_e              r_s1_mode;
`else
  logic               w_unused_mode;
  assign w_unused_mode = bus.iMODE;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_s1_val  <= 1'b0;
      r_s1_cur  <= '0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
`ifdef BAYER_DEMOSAIC_RGB_EN
      r_s1_mode <= MODE_GREY;
`endif
    end else begin
      r_s1_val <= w_acc;
      if (w_acc) begin
        r_s1_cur  <= bus.iDATA;
        r_s1_x    <= bus.iX_Cont;
        r_s1_y    <= bus.iY_Cont;
`ifdef BAYER_DEMOSAIC_RGB_EN
        r_s1_mode <= mode_e'(bus.iMODE);
`endif
      end
    end
  end

  logic [DATA_W-1:0]  r_left;
  logic [DATA_W-1:0]  r_upleft;
  logic               r_row_ok;
  logic               r_have_y;
  logic [COORD_W-1:0] r_last_y;

  logic               w_new_row;
  logic               w_top;
  logic               w_row_ok_next;
  logic [DATA_W-1:0]  w_left;
  logic [DATA_W-1:0]  w_up;
  logic [DATA_W-1:0]  w_upleft;
  logic [DATA_W-1:0]  w_win  [4];
  logic [DATA_W-1:0]  w_chan [4];
  bayer_color_e       w_cur_color;
  logic [GREY_W-1:0]  w_grey_sum;
  logic [DATA_W-1:0]  w_grey;
  logic [DATA_W-1:0]  w_red;
  logic [DATA_W-1:0]  w_green;
  logic [DATA_W-1:0]  w_blue;

  // A row counts as having a valid line above only after a y change seen since reset.
  assign w_new_row     = r_have_y && (r_s1_y != r_last_y);
  assign w_top         = (r_s1_y == '0) || !(w_new_row || r_row_ok);
  assign w_row_ok_next = (r_s1_y != '0) && (w_new_row || r_row_ok || (r_s1_x == X_LAST));
  assign w_cur_color   = bayer_color(r_s1_y[0], r_s1_x[0], BAYER_PHASE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_left   = r_left;
    w_up     = w_rd_data;
    w_upleft = r_upleft;
    if (r_s1_x == '0) begin
      w_left   = r_s1_cur;
      w_upleft = w_rd_data;
    end
    if (w_top) begin
      w_up     = r_s1_cur;
      w_upleft = w_left;
    end
  end

  // Window slot k holds the element whose colour code is the cur code XOR k.
  always_comb begin
    w_win[0] = r_s1_cur;
    w_win[1] = w_left;
    w_win[2] = w_up;
    w_win[3] = w_upleft;
    for (int k = 0; k < 4; k++) begin
      w_chan[k] = w_win[2'(k) ^ w_cur_color];
    end
  end

  assign w_grey_sum = GREY_W'(w_chan[R]) + GREY_W'(w_chan[GR]) +
                      GREY_W'(w_chan[GB]) + GREY_W'(w_chan[B]);
  assign w_grey     = DATA_W'(w_grey_sum >> 2);

`ifdef BAYER_DEMOSAIC_RGB_EN
  localparam int GSUM_W = DATA_W + 1;
  logic [GSUM_W-1:0] w_g_sum;
  assign w_g_sum = GSUM_W'(w_chan[GR]) + GSUM_W'(w_chan[GB]);
`endif

  always_comb begin
    w_red   = w_grey;
    w_green = w_grey;
    w_blue  = w_grey;
`ifdef BAYER_DEMOSAIC_RGB_EN
    if (r_s1_mode == MODE_RGB) begin
      w_red   = w_chan[R];
      w_green = DATA_W'(w_g_sum >> 1);
      w_blue  = w_chan[B];
    end
`endif
  end

  logic               r_out_val;
  logic [DATA_W-1:0]  r_red;
  logic [DATA_W-1:0]  r_green;
  logic [DATA_W-1:0]  r_blue;
  logic [COORD_W-1:0] r_out_x;
  logic [COORD_W-1:0] r_out_y;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_out_val <= 1'b0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_out_x   <= '0;
      r_out_y   <= '0;
      r_left    <= '0;
      r_upleft  <= '0;
      r_row_ok  <= 1'b0;
      r_have_y  <= 1'b0;
      r_last_y  <= '0;
    end else begin
      r_out_val <= r_s1_val;
      if (r_s1_val) begin
        r_red    <= w_red;
        r_green  <= w_green;
        r_blue   <= w_blue;
        r_out_x  <= r_s1_x;
        r_out_y  <= r_s1_y;
        r_left   <= r_s1_cur;
        r_upleft <= w_rd_data;
        r_row_ok <= w_row_ok_next;
        r_have_y <= 1'b1;
        r_last_y <= r_s1_y;
      end
    end
  end

  assign bus.oDVAL   = r_out_val;
  assign bus.oRED    = r_red;
  assign bus.oGREEN  = r_green;
  assign bus.oBLUE   = r_blue;
  assign bus.oX_Cont = r_out_x;
  assign bus.oY_Cont = r_out_y;
endmodule

// File: tb/tb_bayer_demosaic.sv
// Directed bench for bayer_demosaic (LINE_W=8, phase R at (0,0)); RGB expectations
// follow BAYER_DEMOSAIC_RGB_EN, otherwise iMODE=1 must still yield greyscale.
`timescale 1ns/1ps
module tb_bayer_demosaic;
  localparam int DATA_W  = 12;
  localparam int COORD_W = 11;
  localparam int LINE_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bayer_demosaic_if #(.DATA_W(DATA_W), .COORD_W(COORD_W)) bus ();

  bayer_demosaic #(
    .DATA_W     (DATA_W),
    .COORD_W    (COORD_W),
    .LINE_W     (LINE_W),
    .BAYER_PHASE(2'b00)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  typedef struct {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DATA_W-1:0]  r;
    logic [DATA_W-1:0]  g;
    logic [DATA_W-1:0]  b;
    int                 cyc;
  } obs_t;

  obs_t obs_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (bus.oDVAL === 1'b1) begin
      o.x = bus.oX_Cont; o.y = bus.oY_Cont;
      o.r = bus.oRED; o.g = bus.oGREEN; o.b = bus.oBLUE;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic px(input int x, input int y, input int d, input logic m);
    @(negedge clk);
    bus.iX_Cont = COORD_W'(x);
    bus.iY_Cont = COORD_W'(y);
    bus.iDATA   = DATA_W'(d);
    bus.iMODE   = m;
    bus.iDVAL   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.iDVAL = 1'b0;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    bus.iDVAL = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oDVAL !== 1'b0) begin
      errors++; $display("FAIL reset_dval: got %b expected 0", bus.oDVAL);
    end
    checks++;
    if ({bus.oRED, bus.oGREEN, bus.oBLUE} !== '0) begin
      errors++; $display("FAIL reset_rgb: got %0d/%0d/%0d expected 0/0/0", bus.oRED, bus.oGREEN, bus.oBLUE);
    end
    checks++;
    if ({bus.oX_Cont, bus.oY_Cont} !== '0) begin
      errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", bus.oX_Cont, bus.oY_Cont);
    end
    rst = 1'b0;
  endtask

  task automatic test_flat_frame;
    int c0 = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      px(i % 4, i / 4, 100, 1'b0);
      if (i == 0) c0 = cyc;
    end
    idle(4);
    checks++;
    if (obs_q.size() != 16) begin
      errors++; $display("FAIL flat_count: got %0d expected 16", obs_q.size());
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].cyc != c0 + 2) begin
      errors++; $display("FAIL flat_latency: got %0d cycles expected 2", obs_q[0].cyc - c0);
    end
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].x !== COORD_W'(i % 4) || obs_q[i].y !== COORD_W'(i / 4) ||
          obs_q[i].r !== 12'd100 || obs_q[i].g !== 12'd100 || obs_q[i].b !== 12'd100) begin
        errors++;
        $display("FAIL flat_px%0d: got (%0d,%0d) %0d/%0d/%0d expected (%0d,%0d) 100/100/100",
                 i, obs_q[i].x, obs_q[i].y, obs_q[i].r, obs_q[i].g, obs_q[i].b, i % 4, i / 4);
      end
    end
  endtask

  task automatic test_colour;
    int vals[4] = '{400, 200, 200, 40};
    int grey[4] = '{400, 300, 300, 210};
`ifdef BAYER_DEMOSAIC_RGB_EN
    int rgb_r[4] = '{400, 400, 400, 400};
    int rgb_g[4] = '{400, 300, 300, 200};
    int rgb_b[4] = '{400, 200, 200, 40};
`else
    int rgb_r[4] = '{400, 300, 300, 210};
    int rgb_g[4] = '{400, 300, 300, 210};
    int rgb_b[4] = '{400, 300, 300, 210};
`endif
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 4; i++) px(i % 2, i / 2, vals[i], run == 0);
      idle(4);
      checks++;
      if (obs_q.size() != 4) begin
        errors++; $display("FAIL colour_count run%0d: got %0d expected 4", run, obs_q.size());
      end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
        int er = (run == 0) ? rgb_r[i] : grey[i];
        int eg = (run == 0) ? rgb_g[i] : grey[i];
        int eb = (run == 0) ? rgb_b[i] : grey[i];
        checks++;
        if (obs_q[i].r !== DATA_W'(er) || obs_q[i].g !== DATA_W'(eg) || obs_q[i].b !== DATA_W'(eb)) begin
          errors++;
          $display("FAIL colour run%0d px(%0d,%0d): got %0d/%0d/%0d expected %0d/%0d/%0d",
                   run, i % 2, i / 2, obs_q[i].r, obs_q[i].g, obs_q[i].b, er, eg, eb);
        end
      end
    end
  endtask

  task automatic test_replicate;
    int exp_v[2] = '{8, 10};
    do_reset();
    px(0, 0, 8, 1'b0);
    px(1, 0, 12, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL replicate_count: got %0d expected 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].r !== DATA_W'(exp_v[i]) || obs_q[i].g !== DATA_W'(exp_v[i]) ||
          obs_q[i].b !== DATA_W'(exp_v[i])) begin
        errors++;
        $display("FAIL replicate_px%0d: got %0d/%0d/%0d expected %0d",
                 i, obs_q[i].r, obs_q[i].g, obs_q[i].b, exp_v[i]);
      end
    end
  endtask

  task automatic test_gaps;
    int vals[8]  = '{10, 20, 30, 40, 50, 60, 70, 80};
    int exp_v[8] = '{10, 15, 25, 35, 30, 35, 45, 55};
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        px(i % 4, i / 4, vals[i], 1'b0);
        if (run == 1) idle(3);
      end
      idle(4);
      checks++;
      if (obs_q.size() != 8) begin
        errors++; $display("FAIL gaps_count run%0d: got %0d expected 8", run, obs_q.size());
      end
      for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i].x !== COORD_W'(i % 4) || obs_q[i].y !== COORD_W'(i / 4) ||
            obs_q[i].r !== DATA_W'(exp_v[i]) || obs_q[i].g !== DATA_W'(exp_v[i]) ||
            obs_q[i].b !== DATA_W'(exp_v[i])) begin
          errors++;
          $display("FAIL gaps run%0d px%0d: got (%0d,%0d) %0d/%0d/%0d expected (%0d,%0d) %0d",
                   run, i, obs_q[i].x, obs_q[i].y, obs_q[i].r, obs_q[i].g, obs_q[i].b,
                   i % 4, i / 4, exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    int exp_x[3] = '{6, 7, 0};
    int exp_y[3] = '{3, 3, 4};
    int exp_v[3] = '{50, 100, 100};
    do_reset();
    for (int x = 0; x < 8; x++) px(x, 2, 4095, 1'b0);
    for (int x = 0; x < 5; x++) px(x, 3, 100, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    checks++;
    if (bus.oDVAL !== 1'b1) begin
      errors++; $display("FAIL midreset_pre_dval: got %b expected 1", bus.oDVAL);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.oDVAL !== 1'b0 || bus.oRED !== '0) begin
      errors++; $display("FAIL midreset_async: got dval=%b red=%0d expected dval=0 red=0", bus.oDVAL, bus.oRED);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    px(6, 3, 100, 1'b0);
    px(7, 3, 100, 1'b0);
    px(0, 4, 100, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL midreset_count: got %0d expected 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].x !== COORD_W'(exp_x[i]) || obs_q[i].y !== COORD_W'(exp_y[i]) ||
          obs_q[i].r !== DATA_W'(exp_v[i])) begin
        errors++;
        $display("FAIL midreset px%0d: got (%0d,%0d) %0d expected (%0d,%0d) %0d",
                 i, obs_q[i].x, obs_q[i].y, obs_q[i].r, exp_x[i], exp_y[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_out_of_range;
    int exp_x[4] = '{0, 1, 0, 1};
    int exp_y[4] = '{0, 0, 1, 1};
    int exp_v[4] = '{4000, 4047, 4047, 4071};
    do_reset();
    px(0, 0, 4000, 1'b0);
    px(1, 0, 4095, 1'b0);
    px(LINE_W, 0, 4095, 1'b0);
    px(0, 1, 4095, 1'b0);
    px(1, 1, 4095, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 4) begin
      errors++; $display("FAIL range_count: got %0d expected 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].x !== COORD_W'(exp_x[i]) || obs_q[i].y !== COORD_W'(exp_y[i]) ||
          obs_q[i].r !== DATA_W'(exp_v[i]) || obs_q[i].b !== DATA_W'(exp_v[i])) begin
        errors++;
        $display("FAIL range px%0d: got (%0d,%0d) %0d/%0d expected (%0d,%0d) %0d",
                 i, obs_q[i].x, obs_q[i].y, obs_q[i].r, obs_q[i].b, exp_x[i], exp_y[i], exp_v[i]);
      end
    end
  endtask

  initial begin
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    bus.iDATA   = '0;
    bus.iDVAL   = 1'b0;
    bus.iMODE   = 1'b0;
    test_reset();
    test_flat_frame();
    test_colour();
    test_replicate();
    test_gaps();
    test_mid_reset();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bayer_demosaic.md
# bayer_demosaic

Parametrised successor to the camera-path 2x2 greyscale stage: takes raw Bayer pixels with their X/Y coordinates from the sensor capture block and produces, per input pixel, either a greyscale value or a full R/G/B triple built from the 2x2 window ending at that pixel. It sits between capture and the frame-buffer/display path. It adds several behaviours the previous stage lacked:

- a RAM-backed, valid-gated line buffer;
- Bayer phase selection;
- border replication that survives a mid-frame reset;
- a run-time mode select.

## Interface
Parameters:
- DATA_W, 12, raw pixel width.
- COORD_W, 11, coordinate width.
- LINE_W, 1280, maximum pixels per line (line buffer depth).
- BAYER_PHASE, 2'b00, colour of pixel (0,0): 0=R, 1=Gr, 2=Gb, 3=B.

Ports:
- iCLK  in  1  clock; one clock domain, all logic on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iX_Cont  in  COORD_W  column of iDATA.
- iY_Cont  in  COORD_W  row of iDATA.
- iDATA  in  DATA_W  raw Bayer sample.
- iDVAL  in  1  iDATA/coordinates valid this cycle.
- iMODE  in  1  0 = greyscale, 1 = RGB; sampled with each valid pixel.
- oRED, oGREEN, oBLUE  out  DATA_W each  result channels.
- oX_Cont, oY_Cont  out  COORD_W  coordinates of the result pixel.
- oDVAL  out  1  result valid.

## Operation
- Window for pixel P(x,y) is cur=P(x,y), left=P(x-1,y), up=P(x,y-1), upleft=P(x-1,y-1).
- Line buffer: LINE_W x DATA_W simple dual-port RAM addressed by iX_Cont.
  - Each valid pixel reads the previous row's sample at x, then writes iDATA at x.
  - Invalid cycles neither write nor advance any window history.
- Left and upleft are history registers updated only on valid pixels.
- Borders:
  - x==0: left := cur and upleft := up.
  - Top border: applies while row_ok==0, and then up := cur and upleft := left.
- row_ok flag:
  - Cleared by reset and by any valid pixel with y==0.
  - Set by a valid pixel with x==LINE_W-1 or by the first valid pixel of a new row (y change).
  - This guarantees stale RAM is never used after reset mid-frame.
- Pixels with iX_Cont >= LINE_W are dropped: no RAM write, no oDVAL.
- Colour assignment:
  - Each window element's colour code is {y[0],x[0]} ^ BAYER_PHASE, evaluated at that element's own coordinates.
  - R = element with code 0, B = code 3, G1/G2 = codes 1/2.
  - Under replication, the substituted value is used in the position it replaces.
- Greyscale (iMODE=0): g = (R+G1+G2+B) summed in DATA_W+2 bits, truncated >>2; all three outputs = g.
- RGB (iMODE=1): oRED=R, oBLUE=B, oGREEN=(G1+G2)>>1 summed in DATA_W+1 bits, truncated.
- No saturation is needed; no result can exceed 2^DATA_W-1.

## Timing
- Reset values: all outputs 0, oDVAL 0, row_ok 0, history registers 0. RAM contents are not reset.
- Two-stage pipeline, free-running with no stall:
  - Stage 1 (edge t+1): RAM read data, cur, coordinates, mode and valid are registered.
  - Stage 2 (edge t+2): arithmetic result, coordinates and oDVAL are registered.
- Latency: iDVAL at edge t gives oDVAL at edge t+2 with matching oX/oY_Cont.
- Throughput: one pixel per clock. Back-to-back valid pixels and arbitrary gaps are both legal.
- oDVAL is high exactly one cycle per accepted pixel. Outputs hold their last value while oDVAL is low.
- Read and write to the same address in the same cycle return old data (read-first).
- iRST asserted mid-frame: oDVAL drops asynchronously. The next accepted pixel is processed as a top-border row.

## Configuration
- BAYER_DEMOSAIC_RGB_EN defined: RGB mode present and iMODE honoured.
- Undefined: iMODE ignored and only the greyscale path is built; oRED=oGREEN=oBLUE=g. Latency is unchanged.

## Structure
- bayer_pkg holds:
  - bayer_color_e (R, GR, GB, B);
  - mode_e (MODE_GREY, MODE_RGB);
  - a function mapping coordinate LSBs plus phase to bayer_color_e.
- Sub-module line_buffer (parameters DEPTH, WIDTH): registered-read, read-first simple dual-port RAM. No reset on the storage array.

## Test plan
- Reset then a flat 4x4 frame of value 100, mode grey: every oDVAL output is 100 at X/Y delayed 2 cycles, 16 oDVAL pulses.
- RGGB frame with R=400, G=200, B=40, phase 0, mode RGB, pixel (1,1): oRED=400, oGREEN=200, oBLUE=40. Grey mode gives (400+200+200+40)>>2=210.
- Pixel (0,0) value 8 after reset, grey: output 8 (full replication). Pixel (1,0) value 12: output (8+12+8+12)>>2=10.
- Valid gaps: pixels of one row spaced by 3 idle cycles produce the same results as a back-to-back run. oDVAL count equals input count.
- Reset asserted at (5,3), then stream resumed at (6,3) with RAM holding 4095s: no 4095 contribution appears until the next row.
- iX_Cont=LINE_W with iDVAL=1: no oDVAL, and the RAM entry at 0 is unchanged. Checked with LINE_W=8 and maximum data 4095 (no overflow).
